rasterizer_vertex_writer: RTL and testbench

//  Avalon-MM write master that builds a vertex buffer in SDRAM for the rasterizer vertex fetch.

---
 rtl/rasterizer_vertex_writer.sv | 152 +++++++++++++++
 tb/tb_rasterizer_vertex_writer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rasterizer_vertex_writer.sv
// rasterizer_vertex_writer
// Avalon-MM write master that lays out a vertex buffer in SDRAM for the
// rasterizer vertex fetch. Word 0 at the base holds the triangle count.
// Triangle k's 15 words sit at base + 4 + 60*k.
//
// Handshakes:
//   input side : a record transfers on a rising clock edge where
//                input_valid && input_ready. input_ready is combinational
//                from state and count. It never depends on input_valid.
//   memory side: master_write/address/writedata are registered and held
//                unchanged while master_waitrequest is high. A word is
//                consumed on an edge where master_write && !master_waitrequest.
module rasterizer_vertex_writer #(
  parameter int ADDR_W   = 26,
  parameter int MAX_TRIS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic              master_read,
  output logic [3:0]        master_byteenable,
  output logic [31:0]       master_writedata,
  input  logic              master_waitrequest,
  input  logic              start,
  input  logic [ADDR_W-1:0] vertex_buffer_base,
  input  logic              input_valid,
  output logic              input_ready,
  input  logic [479:0]      vertex_in,
  input  logic              flush,
  output logic              busy,
  output logic              done_out,
  output logic [31:0]       tri_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_WR_TRI = 3'd2,
    S_WR_CNT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;        // word-aligned buffer base (count word)
  logic [ADDR_W-1:0] addr_q;        // address of word 0 of the next triangle
  logic [479:0]      rec_q;         // triangle record being written out
  logic [3:0]        widx_q;        // index of the word currently on the bus
  logic              flush_pend_q;  // flush arrived while a record was in flight

  logic              accept;
  logic [3:0]        widx_nxt;
  logic [31:0]       next_word;
  logic [ADDR_W-1:0] base_aligned;

  assign master_read       = 1'b0;
  assign master_byteenable = 4'b1111;
  assign dbg_state         = state_q;

  assign base_aligned = {vertex_buffer_base[ADDR_W-1:2], 2'b00};
  assign widx_nxt     = widx_q + 4'd1;
  assign next_word    = rec_q[32*widx_nxt +: 32];

  // Accept records only while armed and the buffer still has room.
  always_comb begin
    input_ready = (state_q == S_ARMED) && (tri_count < 32'(MAX_TRIS));
    accept      = input_valid && input_ready;
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  end

  // Buffer FSM with registered bus outputs. Bus signals hold under waitrequest.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      base_q           <= '0;
      addr_q           <= '0;
      rec_q            <= '0;
      widx_q           <= '0;
      flush_pend_q     <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
      done_out         <= 1'b0;
      tri_count        <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q       <= base_aligned;
            addr_q       <= base_aligned + ADDR_W'(4);
            tri_count    <= '0;
            done_out     <= 1'b0;
            flush_pend_q <= 1'b0;
            state_q      <= S_ARMED;
          end
        end

        S_ARMED: begin
          if (accept) begin
            rec_q            <= vertex_in;
            widx_q           <= '0;
            flush_pend_q     <= flush;
            master_write     <= 1'b1;
            master_address   <= addr_q;
            master_writedata <= vertex_in[31:0];
            state_q          <= S_WR_TRI;
          end else if (flush) begin
            master_write     <= 1'b1;
            master_address   <= base_q;
            master_writedata <= tri_count;
            state_q          <= S_WR_CNT;
          end
        end

        S_WR_TRI: begin
          if (flush) flush_pend_q <= 1'b1;
          if (!master_waitrequest) begin
            if (widx_q == 4'd14) begin
              tri_count <= tri_count + 32'd1;
              addr_q    <= addr_q + ADDR_W'(60);
              if (flush_pend_q || flush) begin
                master_address   <= base_q;
                master_writedata <= tri_count + 32'd1;
                state_q          <= S_WR_CNT;
              end else begin
                master_write <= 1'b0;
                state_q      <= S_ARMED;
              end
            end else begin
              widx_q           <= widx_nxt;
              master_address   <= master_address + ADDR_W'(4);
              master_writedata <= next_word;
            end
          end
        end

        S_WR_CNT: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            flush_pend_q <= 1'b0;
            done_out     <= 1'b1;
            state_q      <= S_DONE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rasterizer_vertex_writer.sv
// Self-checking bench for rasterizer_vertex_writer.
// The reference model lists the expected memory writes as (address, data)
// pairs: every word of triangle k at base+4+60k+4i, then the count at base.
// Two instances run side by side: u_dut uses the default capacity, and
// u_dut2 uses MAX_TRIS=2. The sel flag picks which bus gets observed.
module tb_rasterizer_vertex_writer;
  localparam int AW = 26;
  localparam int EW = AW + 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          waitrequest = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic          input_valid = 1'b0;
  logic [479:0]  vertex_in = '0;
  logic          flush = 1'b0;

  logic [AW-1:0] addr1, addr2;
  logic          wr1, wr2, rd1, rd2;
  logic [3:0]    be1, be2;
  logic [31:0]   data1, data2, cnt1, cnt2;
  logic          rdy1, rdy2, busy1, busy2, done1, done2;
  logic [2:0]    st1, st2;

  rasterizer_vertex_writer #(.ADDR_W(AW), .MAX_TRIS(1024)) u_dut (
    .clock(clock), .reset(reset),
    .master_address(addr1), .master_write(wr1), .master_read(rd1),
    .master_byteenable(be1), .master_writedata(data1),
    .master_waitrequest(waitrequest),
    .start(start), .vertex_buffer_base(base),
    .input_valid(input_valid), .input_ready(rdy1), .vertex_in(vertex_in),
    .flush(flush), .busy(busy1), .done_out(done1), .tri_count(cnt1),
    .dbg_state(st1)
  );

  rasterizer_vertex_writer #(.ADDR_W(AW), .MAX_TRIS(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .master_address(addr2), .master_write(wr2), .master_read(rd2),
    .master_byteenable(be2), .master_writedata(data2),
    .master_waitrequest(waitrequest),
    .start(start), .vertex_buffer_base(base),
    .input_valid(input_valid), .input_ready(rdy2), .vertex_in(vertex_in),
    .flush(flush), .busy(busy2), .done_out(done2), .tri_count(cnt2),
    .dbg_state(st2)
  );

  // Observed-bus selection.
  logic          sel = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_wr, m_rdy, m_busy, m_done;
  logic [31:0]   m_data, m_cnt;
  assign m_addr = sel ? addr2 : addr1;
  assign m_wr   = sel ? wr2   : wr1;
  assign m_data = sel ? data2 : data1;
  assign m_rdy  = sel ? rdy2  : rdy1;
  assign m_busy = sel ? busy2 : busy1;
  assign m_done = sel ? done2 : done1;
  assign m_cnt  = sel ? cnt2  : cnt1;

  int tests = 0;
  int failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic          rand_wait = 1'b0;
  logic          chk_stable = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [31:0]   p_data = '0;

  // Clock and reset.
  always #5 clock = ~clock;

  // The slave stall is randomised just after each edge while enabled.
  always @(posedge clock) begin
    #1;
    waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Bus monitor: log accepted writes, and check that the bus holds steady under stall.
  always @(negedge clock) begin
    if (m_wr && !waitrequest && !reset) obs_q.push_back({m_addr, m_data});
    if (chk_stable && prev_stall) begin
      tests++;
      if (!(m_wr && m_addr == p_addr && m_data == p_data)) begin
        failed++;
        $display("FAIL stall_hold: got wr=%0b addr=%h data=%h, need wr=1 addr=%h data=%h",
                 m_wr, m_addr, m_data, p_addr, p_data);
      end
    end
    prev_stall = m_wr && waitrequest && !reset;
    p_addr = m_addr;
    p_data = m_data;
  end

  // Reference model.
  task automatic model_tri(input logic [AW-1:0] b, input int k, input logic [479:0] rec);
    for (int i = 0; i < 15; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(4 + 60 * k + 4 * i);
      exp_q.push_back({a, rec[32*i +: 32]});
    end
  endtask

  task automatic model_count(input logic [AW-1:0] b, input int n);
    exp_q.push_back({b, 32'(n)});
  endtask

  function automatic logic [479:0] rand_rec();
    logic [479:0] r;
    for (int i = 0; i < 15; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Drivers.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; input_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    obs_q.delete();
    exp_q.delete();
    @(posedge clock); #1;
    base = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_tri(input logic [479:0] rec, input logic with_flush);
    int n = 0;
    input_valid = 1'b1;
    vertex_in = rec;
    @(negedge clock);
    while (!m_rdy && n < 3000) begin @(negedge clock); n++; end
    if (n >= 3000) begin
      tests++; failed++;
      $display("FAIL send_timeout: input_ready stayed 0, need 1");
    end
    flush = with_flush;
    @(posedge clock); #1;
    input_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    @(negedge clock);
    while (!m_busy && n < 100) begin @(negedge clock); n++; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while (!m_done && n < 5000) begin @(negedge clock); n++; end
    tests++;
    if (!m_done) begin
      failed++;
      $display("FAIL done_timeout: done_out=0, need 1");
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic check_writes(input string name, input int cnt);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      failed++;
      $display("FAIL %s_nwrites: got %0d, need %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++;
        $display("FAIL %s_write%0d: got addr=%h data=%h, need addr=%h data=%h", name, i,
                 obs_q[i][EW-1:32], obs_q[i][31:0], exp_q[i][EW-1:32], exp_q[i][31:0]);
      end
    end
    tests++;
    if (m_cnt !== 32'(cnt) || m_busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_final: got tri_count=%0d busy=%0b, need %0d busy=0", name, m_cnt, m_busy, cnt);
    end
  endtask

  // Scenarios.
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    tests++;
    if (wr1 !== 1'b0 || addr1 !== '0 || data1 !== '0 || rdy1 !== 1'b0 ||
        done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== '0 || rd1 !== 1'b0 || be1 !== 4'hF) begin
      failed++;
      $display("FAIL reset: got wr=%0b addr=%h data=%h rdy=%0b done=%0b busy=%0b cnt=%0d rd=%0b be=%h, need 0s rd=0 be=f",
               wr1, addr1, data1, rdy1, done1, busy1, cnt1, rd1, be1);
    end
  endtask

  task automatic test_single_tri();
    logic [479:0] rec;
    for (int i = 0; i < 15; i++) rec[32*i +: 32] = 32'hA0 + 32'(i);
    sel = 1'b0;
    do_start(26'h100);
    model_tri(26'h100, 0, rec);
    model_count(26'h100, 1);
    send_tri(rec, 1'b0);
    @(negedge clock);
    tests++;
    if (m_wr !== 1'b1 || m_addr !== 26'h104 || m_data !== 32'hA0) begin
      failed++;
      $display("FAIL t1_first_word: got wr=%0b addr=%h data=%h, need 1 104 a0", m_wr, m_addr, m_data);
    end
    repeat (15) @(negedge clock);
    tests++;
    if (m_wr !== 1'b0 || m_rdy !== 1'b1) begin
      failed++;
      $display("FAIL t1_rearm: got wr=%0b rdy=%0b, need wr=0 rdy=1", m_wr, m_rdy);
    end
    do_flush();
    wait_done();
    check_writes("t1", 1);
  endtask

  task automatic test_back_to_back();
    logic [479:0] rec;
    sel = 1'b0;
    do_start(26'h100);
    rand_wait = 1'b1;
    chk_stable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rec = rand_rec();
      model_tri(26'h100, k, rec);
      send_tri(rec, 1'b0);
    end
    model_count(26'h100, 3);
    do_flush();
    wait_done();
    rand_wait = 1'b0;
    chk_stable = 1'b0;
    check_writes("t2", 3);
  endtask

  task automatic test_flush_with_accept();
    logic [479:0] rec;
    sel = 1'b0;
    rec = rand_rec();
    do_start(26'h3FFFFD0);   // also wraps the address space
    model_tri(26'h3FFFFD0, 0, rec);
    model_count(26'h3FFFFD0, 1);
    send_tri(rec, 1'b1);
    wait_done();
    check_writes("t3", 1);
  endtask

  task automatic test_empty_flush();
    sel = 1'b0;
    do_start(26'h2000);
    model_count(26'h2000, 0);
    do_flush();
    wait_done();
    check_writes("t4", 0);
  endtask

  task automatic test_max_tris();
    logic [479:0] rec;
    sel = 1'b1;
    do_reset();
    do_start(26'h40);
    for (int k = 0; k < 2; k++) begin
      rec = rand_rec();
      model_tri(26'h40, k, rec);
      send_tri(rec, 1'b0);
    end
    repeat (20) @(negedge clock);
    input_valid = 1'b1;
    vertex_in = rand_rec();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests++;
      if (m_rdy !== 1'b0 || m_wr !== 1'b0) begin
        failed++;
        $display("FAIL t5_full: got rdy=%0b wr=%0b, need 0 0", m_rdy, m_wr);
      end
    end
    input_valid = 1'b0;
    model_count(26'h40, 2);
    do_flush();
    wait_done();
    check_writes("t5", 2);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [479:0] rec;
    int n = 0;
    sel = 1'b0;
    rec = rand_rec();
    do_start(26'h400);
    input_valid = 1'b1;
    vertex_in = rec;
    @(negedge clock);
    while (!(m_wr && m_addr == 26'h420) && n < 200) begin
      @(negedge clock);
      n++;
      if (m_wr) input_valid = 1'b0;
    end
    input_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if (m_wr !== 1'b0 || m_busy !== 1'b0 || m_cnt !== '0 || m_done !== 1'b0 || st1 !== 3'd0) begin
      failed++;
      $display("FAIL t6_reset: got wr=%0b busy=%0b cnt=%0d done=%0b st=%0d, need 0 0 0 0 0",
               m_wr, m_busy, m_cnt, m_done, st1);
    end
    #1 reset = 1'b0;
    rec = rand_rec();
    do_start(26'h800);
    model_tri(26'h800, 0, rec);
    model_count(26'h800, 1);
    send_tri(rec, 1'b0);
    do_flush();
    wait_done();
    check_writes("t6", 1);
  endtask

  initial begin
    test_reset();
    test_single_tri();
    test_back_to_back();
    test_flush_with_accept();
    test_empty_flush();
    test_max_tris();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, need finish");
    $fatal(1, "timeout");
  end

endmodule
